hazard_ctl: RTL and testbench

//  Pipeline sequencing controller for the fetch/decode/execute front end.
//  - Watches the instruction held in the decode register, plus EX-stage status.
//  - Drives stall, flush and bubble controls for the fetch and decode pipeline registers.
//  - Handles three cases: load-use hazards, taken branch/jump redirects, and FENCE/SYSTEM drains.
//  - Keeps a saturating count of stall cycles for performance monitoring.

---
 rtl/hazard_ctl.sv | 92 +++++++++
 tb/tb_hazard_ctl.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/hazard_ctl.sv
// hazard_ctl: front-end sequencing for load-use stalls, redirects and FENCE/SYSTEM drains
module hazard_ctl #(
    parameter int LOAD_STALL  = 1,
    parameter int DRAIN_DEPTH = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr_de,
    input  logic        de_valid,
    input  logic        ex_valid,
    input  logic        ex_is_load,
    input  logic [4:0]  ex_rd,
    input  logic        redirect,
    output logic        stall_fe,
    output logic        stall_de,
    output logic        bubble_ex,
    output logic        flush_de,
    output logic        pc_sel,
    output logic [1:0]  busy_state,
    output logic [31:0] stall_cycles
);
    localparam logic [1:0] RUN = 2'd0, LDSTALL = 2'd1, DRAIN = 2'd2;
    logic [1:0] state, state_nx;
    logic [2:0] cnt, cnt_nx;
    logic       drain_done, drain_done_nx;
    logic [6:0] op;
    logic [4:0] rs1, rs2;
    logic       rs1_used, rs2_used, hazard, sync_req, stall;
    logic       unused_bits;
    assign op          = instr_de[6:0];
    assign rs1         = instr_de[19:15];
    assign rs2         = instr_de[24:20];
    assign unused_bits = ^{instr_de[31:25], instr_de[14:7]};
    assign rs1_used = op inside {7'b1100111, 7'b1100011, 7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011};
    assign rs2_used = op inside {7'b1100011, 7'b0100011, 7'b0110011};
    assign hazard   = de_valid & ex_valid & ex_is_load & (ex_rd != 5'd0) &
                      ((rs1_used & (rs1 == ex_rd)) | (rs2_used & (rs2 == ex_rd)));
    assign sync_req = de_valid & ((op == 7'b0001111) | (op == 7'b1110011)) & ~drain_done;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= RUN;
            cnt          <= 3'd0;
            drain_done   <= 1'b0;
            stall_cycles <= 32'd0;
        end else begin
            state        <= state_nx;
            cnt          <= cnt_nx;
            drain_done   <= drain_done_nx;
            stall_cycles <= (stall_de && stall_cycles != 32'hFFFF_FFFF) ? stall_cycles + 32'd1 : stall_cycles;
        end
    end
    always_comb begin
        state_nx      = state;
        cnt_nx        = cnt;
        drain_done_nx = drain_done;
        if (redirect) begin
            state_nx      = RUN;
            cnt_nx        = 3'd0;
            drain_done_nx = 1'b0;
        end else if (state != RUN) begin
            cnt_nx = cnt - 3'd1;
            if (cnt == 3'd1) begin
                state_nx      = RUN;
                drain_done_nx = drain_done | (state == DRAIN);
            end
        end else if (hazard) begin
            if (LOAD_STALL > 1) begin
                state_nx = LDSTALL;
                cnt_nx   = 3'(LOAD_STALL - 1);
            end
        end else if (sync_req) begin
            if (DRAIN_DEPTH > 1) begin
                state_nx = DRAIN;
                cnt_nx   = 3'(DRAIN_DEPTH - 1);
            end else begin
                drain_done_nx = 1'b1;
            end
        end else begin
            // the drained FENCE/SYSTEM has now issued
            drain_done_nx = 1'b0;
        end
    end
    always_comb begin
        stall     = rst_n & ~redirect & ((state != RUN) | hazard | sync_req);
        stall_fe  = stall;
        stall_de  = stall;
        bubble_ex = stall | (rst_n & redirect);
        flush_de  = rst_n & redirect;
        pc_sel    = rst_n & redirect;
    end
    assign busy_state = state;
endmodule

// File: tb/tb_hazard_ctl.sv
// tb_hazard_ctl: two parameterisations checked against a remaining-cycles behavioural model
module tb_hazard_ctl;
    logic        clk, rst_n, de_valid, ex_valid, ex_is_load, redirect;
    logic [31:0] instr_de;
    logic [4:0]  ex_rd;
    logic        s_fe[2], s_de[2], bub[2], fl[2], pcs[2];
    logic [1:0]  bs[2];
    logic [31:0] sc[2];
    int          n_tests = 0, n_fail = 0;
    int          m_rem[2]  = '{0, 0};
    int          m_kind[2] = '{0, 0};
    bit          m_drained[2] = '{0, 0};
    logic [31:0] m_sc[2] = '{32'd0, 32'd0};

    hazard_ctl #(.LOAD_STALL(1), .DRAIN_DEPTH(3)) u0 (
        .clk(clk), .rst_n(rst_n), .instr_de(instr_de), .de_valid(de_valid), .ex_valid(ex_valid),
        .ex_is_load(ex_is_load), .ex_rd(ex_rd), .redirect(redirect), .stall_fe(s_fe[0]), .stall_de(s_de[0]),
        .bubble_ex(bub[0]), .flush_de(fl[0]), .pc_sel(pcs[0]), .busy_state(bs[0]), .stall_cycles(sc[0]));
    hazard_ctl #(.LOAD_STALL(3), .DRAIN_DEPTH(1)) u1 (
        .clk(clk), .rst_n(rst_n), .instr_de(instr_de), .de_valid(de_valid), .ex_valid(ex_valid),
        .ex_is_load(ex_is_load), .ex_rd(ex_rd), .redirect(redirect), .stall_fe(s_fe[1]), .stall_de(s_de[1]),
        .bubble_ex(bub[1]), .flush_de(fl[1]), .pc_sel(pcs[1]), .busy_state(bs[1]), .stall_cycles(sc[1]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit uses_rs1(input logic [6:0] op);
        return op inside {7'b1100111, 7'b1100011, 7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011};
    endfunction

    function automatic bit uses_rs2(input logic [6:0] op);
        return op inside {7'b1100011, 7'b0100011, 7'b0110011};
    endfunction

    function automatic logic [31:0] rnd_instr();
        logic [6:0] op;
        case ($urandom_range(0, 11))
            0: op = 7'b0110111;  1: op = 7'b0010111;  2: op = 7'b1101111;  3: op = 7'b1100111;
            4: op = 7'b1100011;  5: op = 7'b0000011;  6: op = 7'b0100011;  7: op = 7'b0010011;
            8: op = 7'b0110011;  9: op = 7'b0001111; 10: op = 7'b1110011; default: op = 7'($urandom);
        endcase
        return {7'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 3'($urandom), 5'($urandom), op};
    endfunction

    // model: a stall is a run of remaining cycles; a finished drain lets the sync instr issue once
    initial begin
        bit haz, syn, est, erd;
        int lsv, ddv, ebs;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                lsv = (i == 0) ? 1 : 3;
                ddv = (i == 0) ? 3 : 1;
                haz = de_valid && ex_valid && ex_is_load && ex_rd != 5'd0 &&
                      ((uses_rs1(instr_de[6:0]) && instr_de[19:15] == ex_rd) ||
                       (uses_rs2(instr_de[6:0]) && instr_de[24:20] == ex_rd));
                syn = de_valid && (instr_de[6:0] == 7'b0001111 || instr_de[6:0] == 7'b1110011) && !m_drained[i];
                if (!rst_n) begin
                    m_rem[i] = 0; m_kind[i] = 0; m_drained[i] = 0; m_sc[i] = 32'd0;
                    erd = 0; est = 0;
                end else begin
                    erd = redirect;
                    est = !redirect && (m_rem[i] > 0 || haz || syn);
                end
                ebs = (m_rem[i] > 0) ? m_kind[i] : 0;
                chk($sformatf("u%0d.stall_fe", i), 32'(s_fe[i]), 32'(est));
                chk($sformatf("u%0d.stall_de", i), 32'(s_de[i]), 32'(est));
                chk($sformatf("u%0d.bubble_ex", i), 32'(bub[i]), 32'(est | erd));
                chk($sformatf("u%0d.flush_de", i), 32'(fl[i]), 32'(erd));
                chk($sformatf("u%0d.pc_sel", i), 32'(pcs[i]), 32'(erd));
                chk($sformatf("u%0d.busy_state", i), 32'(bs[i]), 32'(ebs));
                chk($sformatf("u%0d.stall_cycles", i), sc[i], m_sc[i]);
                if (rst_n) begin
                    if (est && m_sc[i] != 32'hFFFF_FFFF) m_sc[i] = m_sc[i] + 32'd1;
                    if (redirect) begin
                        m_rem[i] = 0; m_drained[i] = 0;
                    end else if (m_rem[i] > 0) begin
                        m_rem[i]--;
                        if (m_rem[i] == 0 && m_kind[i] == 2) m_drained[i] = 1;
                    end else if (haz) begin
                        m_rem[i] = lsv - 1; m_kind[i] = 1;
                    end else if (syn) begin
                        m_rem[i] = ddv - 1; m_kind[i] = 2;
                        if (ddv == 1) m_drained[i] = 1;
                    end else begin
                        m_drained[i] = 0;
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic look();
        @(negedge clk);
        #1;
    endtask

    initial begin
        rst_n = 0; redirect = 1; de_valid = 1; ex_valid = 1; ex_is_load = 1; ex_rd = 5'd5;
        instr_de = 32'h002280B3;
        look();
        for (int i = 0; i < 2; i++) begin
            chk("rst.stall_de", 32'(s_de[i]), 0);
            chk("rst.pc_sel", 32'(pcs[i]), 0);
            chk("rst.flush_de", 32'(fl[i]), 0);
            chk("rst.bubble_ex", 32'(bub[i]), 0);
            chk("rst.busy", 32'(bs[i]), 0);
            chk("rst.cycles", sc[i], 0);
        end
        step(); rst_n = 1; redirect = 0;
        look(); chk("ld.stall_de", 32'(s_de[0]), 1); chk("ld.bubble", 32'(bub[0]), 1);
        step(); ex_valid = 0;
        look(); chk("ld.release", 32'(s_de[0]), 0); chk("ld.cycles", sc[0], 1);
        repeat (3) step();
        ex_valid = 1; ex_rd = 5'd0;
        look(); chk("rd0.u0", 32'(s_de[0]), 0); chk("rd0.u1", 32'(s_de[1]), 0);
        step(); ex_rd = 5'd5; instr_de = 32'h000052B7;
        look(); chk("lui.u0", 32'(s_de[0]), 0); chk("lui.u1", 32'(s_de[1]), 0);
        step(); ex_valid = 0; instr_de = 32'h0000000F;
        look(); chk("fence.c1", 32'(s_de[0]), 1);
        step(); look(); chk("fence.c2", 32'(s_de[0]), 1); chk("fence.busy", 32'(bs[0]), 2);
        step(); look(); chk("fence.c3", 32'(s_de[0]), 1);
        step(); look(); chk("fence.issue", 32'(s_de[0]), 0); chk("fence.run", 32'(bs[0]), 0);
        step(); instr_de = 32'h00000013;
        look(); chk("fence.after", 32'(s_de[0]), 0);
        step(); ex_valid = 1; ex_is_load = 1; ex_rd = 5'd5; instr_de = 32'h002280B3;
        look(); chk("abort.c1", 32'(s_de[1]), 1);
        step(); redirect = 1;
        look();
        chk("abort.pc_sel", 32'(pcs[1]), 1); chk("abort.flush", 32'(fl[1]), 1);
        chk("abort.bubble", 32'(bub[1]), 1); chk("abort.stall", 32'(s_de[1]), 0);
        step(); redirect = 0; ex_valid = 0;
        look(); chk("abort.busy", 32'(bs[1]), 0);
        step();
        force u0.stall_cycles = 32'hFFFF_FFFE;
        m_sc[0] = 32'hFFFF_FFFE;
        #1 release u0.stall_cycles;
        ex_valid = 1;
        look(); step(); look(); step(); look();
        step(); ex_valid = 0;
        look(); chk("sat.cycles", sc[0], 32'hFFFF_FFFF);
        for (int k = 0; k < 3000; k++) begin
            step();
            rst_n      = ($urandom_range(0, 199) != 0);
            redirect   = ($urandom_range(0, 9) == 0);
            de_valid   = ($urandom_range(0, 7) != 0);
            ex_valid   = ($urandom_range(0, 3) != 0);
            ex_is_load = 1'($urandom_range(0, 1));
            ex_rd      = 5'($urandom_range(0, 7));
            if ($urandom_range(0, 2) != 0) instr_de = rnd_instr();
        end
        look();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
